// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Holds the instruction width, reset PC and helpers used by the fetch top and its testbench.
package fetch_stage_pkg;

   localparam int          ILEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [ILEN-1:0] instr_t;

   // What happens to an imem response word in the current cycle.
   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_DROP,
      RSP_PUSH
   } rsp_action_e;

   // Anything whose low two bits are not 2'b11 is a 16-bit (compressed) encoding.
   function automatic logic is_illegal(input instr_t instr);
      return instr[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect and the decode-side handshake.
// The master modport is the fetch stage; the slave modport is its environment (imem, execute, decode).
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = 32
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   instr_t          imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   instr_t          id_instr;
   logic            id_illegal;

   modport master (
      output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_illegal,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_illegal,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small in-order FIFO with synchronous flush and occupancy count.
// The head word is read straight from flop storage so dout never depends combinationally on din.
module fetch_stage_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             full;
   logic             pop_en;
   logic             push_en;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
   endfunction

   assign full    = (count_reg == FULL_COUNT);
   assign pop_en  = pop && (count_reg != '0);
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign push_en = push && (!full || pop_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) begin
            mem_reg[wr_ptr_reg] <= din;
            wr_ptr_reg          <= next_ptr(wr_ptr_reg);
         end
         if (pop_en) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         count_reg <= count_reg + CW'(push_en) - CW'(pop_en);
      end
   end

   assign dout  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

   overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && full && !pop_en));

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues in-order imem fetches, buffers returned words
// and hands {pc, instr} to decode. Redirects flush the buffer and drop stale in-flight responses.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);

   localparam int            CW          = $clog2(DEPTH + 1);
   localparam logic [CW:0]   SLOT_LIMIT  = (CW + 1)'(DEPTH);
   localparam int            ENTRY_W     = XLEN + ILEN;

   logic [XLEN-1:0]    pc_reg;
   logic [CW-1:0]      inflight_reg;
   logic [CW-1:0]      drop_reg;
   logic               active_reg;

   logic [CW-1:0]      inflight_next;
   logic [CW:0]        slots_used;
   logic               req_fire;
   logic               buf_pop;
   rsp_action_e        rsp_action;

   logic [ENTRY_W-1:0] buf_dout;
   logic [CW-1:0]      buf_count;
   logic [XLEN-1:0]    pcq_head;
   logic [CW-1:0]      pcq_count;
   logic               unused_redirect_lsbs;

   assign buf_pop = bus.id_valid && bus.id_ready && !bus.redirect_valid;

   // Counting the entry leaving decode this cycle frees its slot immediately, which is what
   // sustains one instruction per cycle with two slots and single-cycle imem.
   assign slots_used = {1'b0, inflight_reg} + {1'b0, buf_count} - (CW + 1)'(buf_pop);

   assign bus.imem_req_valid = active_reg && !bus.redirect_valid && (slots_used < SLOT_LIMIT);
   assign bus.imem_req_addr  = pc_reg;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   always_comb begin
      rsp_action = RSP_NONE;
      if (bus.imem_rsp_valid) begin
         if (bus.redirect_valid || (drop_reg != '0)) begin
            rsp_action = RSP_DROP;
         end else begin
            rsp_action = RSP_PUSH;
         end
      end
   end

   assign inflight_next = inflight_reg + CW'(req_fire) - CW'(bus.imem_rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         inflight_reg <= '0;
         drop_reg     <= '0;
         active_reg   <= 1'b0;
      end else begin
         active_reg   <= 1'b1;
         inflight_reg <= inflight_next;
         if (bus.redirect_valid) begin
            // Every request still outstanding after this cycle belongs to a dead path.
            pc_reg   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_reg <= inflight_next;
         end else begin
            if (req_fire) begin
               pc_reg <= pc_reg + XLEN'(4);
            end
            if (rsp_action == RSP_DROP) begin
               drop_reg <= drop_reg - CW'(1);
            end
         end
      end
   end

   // PCs of live requests, oldest first; consumed as their words land in the buffer.
   fetch_stage_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.redirect_valid),
      .push  (req_fire),
      .din   (pc_reg),
      .pop   (rsp_action == RSP_PUSH),
      .dout  (pcq_head),
      .count (pcq_count)
   );

   fetch_stage_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_instr_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.redirect_valid),
      .push  (rsp_action == RSP_PUSH),
      .din   ({pcq_head, bus.imem_rsp_data}),
      .pop   (buf_pop),
      .dout  (buf_dout),
      .count (buf_count)
   );

   assign bus.id_valid   = (buf_count != '0);
   assign bus.id_pc      = buf_dout[ENTRY_W-1:ILEN];
   assign bus.id_instr   = buf_dout[ILEN-1:0];
   assign bus.id_illegal = is_illegal(bus.id_instr);

   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   live_pc_chk : assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_action == RSP_PUSH) |-> (pcq_count != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with an in-order, fixed-latency imem model.
// Each scenario task drives stimulus and checks the per-cycle trace against hand-derived values.
module tb_fetch_stage;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(32)) bus ();

   fetch_stage #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks    = 0;
   int fails     = 0;
   int cyc       = 0;
   int lat       = 1;
   int data_mode = 0;

   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_instr[$];

   logic        tr_reqv    [0:1023];
   logic        tr_fire    [0:1023];
   logic        tr_idv     [0:1023];
   logic        tr_ill     [0:1023];
   logic [31:0] tr_addr    [0:1023];
   logic [31:0] tr_idpc    [0:1023];
   logic [31:0] tr_idinstr [0:1023];

   function automatic logic [31:0] imem_data(input logic [31:0] a);
      if (data_mode == 1) return a[2] ? 32'h0000_0012 : 32'h0000_0013;
      return {a[31:2], 2'b11};
   endfunction

   // One clock: sample at +1, record accepts and pops, then present the imem response for the next cycle.
   task automatic cycle();
      #1;
      tr_reqv[cyc]    = bus.imem_req_valid;
      tr_fire[cyc]    = bus.imem_req_valid && bus.imem_req_ready;
      tr_addr[cyc]    = bus.imem_req_addr;
      tr_idv[cyc]     = bus.id_valid;
      tr_idpc[cyc]    = bus.id_pc;
      tr_idinstr[cyc] = bus.id_instr;
      tr_ill[cyc]     = bus.id_illegal;
      if (tr_fire[cyc]) begin
         q_addr.push_back(bus.imem_req_addr);
         q_due.push_back(cyc + lat);
         $display("cyc %0d req  addr=%08h", cyc, bus.imem_req_addr);
      end
      if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
         pop_pc.push_back(bus.id_pc);
         pop_instr.push_back(bus.id_instr);
         $display("cyc %0d pop  pc=%08h instr=%08h ill=%b", cyc, bus.id_pc, bus.id_instr, bus.id_illegal);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = imem_data(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q_addr.delete();
      q_due.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.id_ready       = 1'b1;
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
      pop_pc.delete();
      pop_instr.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
      checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b expected 0", bus.id_valid); end
      checks++; if (bus.id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc: got %08h expected 00000000", bus.id_pc); end
      checks++; if (bus.id_instr !== 32'h0) begin fails++; $display("FAIL reset_id_instr: got %08h expected 00000000", bus.id_instr); end
      checks++; if (bus.imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %08h expected 00000000", bus.imem_req_addr); end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_stream();
      int t0;
      int f;
      do_reset();
      lat = 1;
      t0  = cyc;
      f   = -1;
      repeat (16) cycle();
      for (int i = t0; i < t0 + 16; i++) if (tr_fire[i] && f < 0) f = i;
      checks++;
      if (f < 0 || f > t0 + 4) begin
         fails++; $display("FAIL stream_first_accept: got cycle %0d expected %0d..%0d", f, t0, t0 + 4);
      end else begin
         checks++; if (tr_idv[f+1] !== 1'b0) begin fails++; $display("FAIL stream_latency: id_valid %b one cycle after accept, expected 0", tr_idv[f+1]); end
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (tr_fire[f+k] !== 1'b1 || tr_addr[f+k] !== 32'(4 * k)) begin
               fails++; $display("FAIL stream_addr[%0d]: got fire=%b addr=%08h expected fire=1 addr=%08h", k, tr_fire[f+k], tr_addr[f+k], 32'(4 * k));
            end
            checks++;
            if (tr_idv[f+2+k] !== 1'b1 || tr_idpc[f+2+k] !== 32'(4 * k) || tr_idinstr[f+2+k] !== imem_data(32'(4 * k))) begin
               fails++; $display("FAIL stream_id[%0d]: got v=%b pc=%08h instr=%08h expected v=1 pc=%08h instr=%08h",
                                 k, tr_idv[f+2+k], tr_idpc[f+2+k], tr_idinstr[f+2+k], 32'(4 * k), imem_data(32'(4 * k)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int s;
      do_reset();
      lat = 1;
      repeat (3) cycle();
      bus.id_ready = 1'b0;
      s = cyc;
      repeat (5) cycle();
      bus.id_ready = 1'b1;
      repeat (10) cycle();
      for (int i = s; i < s + 5; i++) begin
         checks++; if (tr_reqv[i] !== 1'b0) begin fails++; $display("FAIL bp_issue_stop[%0d]: req_valid %b expected 0", i - s, tr_reqv[i]); end
         checks++;
         if (tr_idv[i] !== 1'b1 || tr_idpc[i] !== 32'h4 || tr_idinstr[i] !== imem_data(32'h4)) begin
            fails++; $display("FAIL bp_hold[%0d]: got v=%b pc=%08h instr=%08h expected v=1 pc=00000004 instr=%08h",
                              i - s, tr_idv[i], tr_idpc[i], tr_idinstr[i], imem_data(32'h4));
         end
      end
      checks++; if (pop_pc.size() < 8) begin fails++; $display("FAIL bp_pop_count: got %0d expected >= 8", pop_pc.size()); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== imem_data(32'(4 * i))) begin
            fails++; $display("FAIL bp_order[%0d]: got pc=%08h instr=%08h expected pc=%08h", i, pop_pc[i], pop_instr[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect_inflight();
      int nf;
      int rd;
      do_reset();
      lat = 3;
      nf  = 0;
      for (int i = 0; i < 10 && nf < 2; i++) begin
         cycle();
         if (tr_fire[cyc-1]) nf++;
      end
      checks++; if (nf != 2) begin fails++; $display("FAIL redir_setup: got %0d accepts expected 2", nf); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0100;
      cycle();
      bus.redirect_valid = 1'b0;
      rd = cyc - 1;
      repeat (14) cycle();
      checks++; if (tr_reqv[rd] !== 1'b0) begin fails++; $display("FAIL redir_no_issue: req_valid %b in redirect cycle expected 0", tr_reqv[rd]); end
      checks++; if (tr_fire[rd+1] !== 1'b0) begin fails++; $display("FAIL redir_slots: accept %b while two stale in flight expected 0", tr_fire[rd+1]); end
      checks++;
      if (tr_fire[rd+2] !== 1'b1 || tr_addr[rd+2] !== 32'h100) begin
         fails++; $display("FAIL redir_addr: got fire=%b addr=%08h expected fire=1 addr=00000100", tr_fire[rd+2], tr_addr[rd+2]);
      end
      for (int i = rd + 1; i <= rd + 5; i++) begin
         checks++; if (tr_idv[i] !== 1'b0) begin fails++; $display("FAIL redir_drop[%0d]: id_valid %b pc=%08h expected 0", i - rd, tr_idv[i], tr_idpc[i]); end
      end
      checks++;
      if (tr_idv[rd+6] !== 1'b1 || tr_idpc[rd+6] !== 32'h100 || tr_idinstr[rd+6] !== imem_data(32'h100)) begin
         fails++; $display("FAIL redir_first_id: got v=%b pc=%08h instr=%08h expected v=1 pc=00000100", tr_idv[rd+6], tr_idpc[rd+6], tr_idinstr[rd+6]);
      end
      checks++; if (pop_pc.size() < 2) begin fails++; $display("FAIL redir_pop_count: got %0d expected >= 2", pop_pc.size()); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== 32'h100 + 32'(4 * i)) begin
            fails++; $display("FAIL redir_order[%0d]: got pc=%08h expected %08h", i, pop_pc[i], 32'h100 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect_pop();
      int rd;
      int rb;
      do_reset();
      lat = 1;
      repeat (6) cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0203;
      #1;
      checks++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL rp_setup: id_valid %b in redirect cycle expected 1", bus.id_valid); end
      cycle();
      bus.redirect_valid = 1'b0;
      rd = cyc - 1;
      repeat (7) cycle();
      checks++; if (tr_idv[rd+1] !== 1'b0) begin fails++; $display("FAIL rp_idv_after: id_valid %b expected 0", tr_idv[rd+1]); end
      checks++;
      if (tr_fire[rd+1] !== 1'b1 || tr_addr[rd+1] !== 32'h200) begin
         fails++; $display("FAIL rp_addr: got fire=%b addr=%08h expected fire=1 addr=00000200", tr_fire[rd+1], tr_addr[rd+1]);
      end
      checks++; if (tr_idv[rd+2] !== 1'b0) begin fails++; $display("FAIL rp_dropped: id_valid %b pc=%08h expected 0", tr_idv[rd+2], tr_idpc[rd+2]); end
      checks++;
      if (tr_idv[rd+3] !== 1'b1 || tr_idpc[rd+3] !== 32'h200 || tr_idinstr[rd+3] !== imem_data(32'h200)) begin
         fails++; $display("FAIL rp_first_id: got v=%b pc=%08h instr=%08h expected v=1 pc=00000200", tr_idv[rd+3], tr_idpc[rd+3], tr_idinstr[rd+3]);
      end
      // back-to-back redirects: only the second target survives
      rb = cyc;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0400;
      cycle();
      bus.redirect_pc    = 32'h0000_0500;
      cycle();
      bus.redirect_valid = 1'b0;
      repeat (4) cycle();
      checks++;
      if (tr_idv[rb+1] !== 1'b0 || tr_reqv[rb+1] !== 1'b0) begin
         fails++; $display("FAIL b2b_mid: got id_valid=%b req_valid=%b expected 0 0", tr_idv[rb+1], tr_reqv[rb+1]);
      end
      checks++;
      if (tr_fire[rb+2] !== 1'b1 || tr_addr[rb+2] !== 32'h500) begin
         fails++; $display("FAIL b2b_addr: got fire=%b addr=%08h expected fire=1 addr=00000500", tr_fire[rb+2], tr_addr[rb+2]);
      end
      checks++;
      if (tr_idv[rb+4] !== 1'b1 || tr_idpc[rb+4] !== 32'h500) begin
         fails++; $display("FAIL b2b_id: got v=%b pc=%08h expected v=1 pc=00000500", tr_idv[rb+4], tr_idpc[rb+4]);
      end
   endtask

   task automatic test_stall_latency();
      int s;
      int stalls;
      do_reset();
      lat    = 3;
      stalls = 0;
      s      = cyc;
      for (int i = 0; i < 40; i++) begin
         bus.imem_req_ready = (i % 2 == 0);
         cycle();
      end
      bus.imem_req_ready = 1'b1;
      repeat (8) cycle();
      for (int i = s; i < s + 39; i++) begin
         if (tr_reqv[i] && !tr_fire[i]) begin
            stalls++;
            checks++;
            if (tr_reqv[i+1] !== 1'b1 || tr_addr[i+1] !== tr_addr[i]) begin
               fails++; $display("FAIL stall_hold[%0d]: next v=%b addr=%08h expected v=1 addr=%08h", i - s, tr_reqv[i+1], tr_addr[i+1], tr_addr[i]);
            end
         end
      end
      checks++; if (stalls == 0) begin fails++; $display("FAIL stall_seen: got 0 stalled requests expected > 0"); end
      checks++; if (pop_pc.size() < 8) begin fails++; $display("FAIL stall_pop_count: got %0d expected >= 8", pop_pc.size()); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== imem_data(32'(4 * i))) begin
            fails++; $display("FAIL stall_order[%0d]: got pc=%08h instr=%08h expected pc=%08h", i, pop_pc[i], pop_instr[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_illegal_reset();
      int t0;
      do_reset();
      lat       = 1;
      data_mode = 1;
      t0        = cyc;
      repeat (4) cycle();
      checks++;
      if (tr_idv[t0+2] !== 1'b1 || tr_idinstr[t0+2] !== 32'h13 || tr_ill[t0+2] !== 1'b0) begin
         fails++; $display("FAIL ill_legal: got v=%b instr=%08h ill=%b expected v=1 instr=00000013 ill=0", tr_idv[t0+2], tr_idinstr[t0+2], tr_ill[t0+2]);
      end
      checks++;
      if (tr_idv[t0+3] !== 1'b1 || tr_idinstr[t0+3] !== 32'h12 || tr_ill[t0+3] !== 1'b1) begin
         fails++; $display("FAIL ill_compressed: got v=%b instr=%08h ill=%b expected v=1 instr=00000012 ill=1", tr_idv[t0+3], tr_idinstr[t0+3], tr_ill[t0+3]);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL areset_id_valid: got %b expected 0", bus.id_valid); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL areset_req_valid: got %b expected 0", bus.imem_req_valid); end
      checks++; if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin fails++; $display("FAIL areset_id_data: got pc=%08h instr=%08h expected 0 0", bus.id_pc, bus.id_instr); end
      checks++; if (bus.imem_req_addr !== 32'h0) begin fails++; $display("FAIL areset_addr: got %08h expected 00000000", bus.imem_req_addr); end
      @(negedge clk);
      data_mode = 0;
      do_reset();
   endtask

   initial begin
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_pop();
      test_stall_latency();
      test_illegal_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
